simeck_dec_arbiter: RTL and testbench
=====================================

// Module: simeck_dec_arbiter
// PURPOSE
//  Shares one Simeck decrypter core (decrypter_top) between two requesters. Requests are arbitrated
//  round-robin. The winner's ciphertext and key are latched and held stable on the core inputs. The
//  block pulses the core's incoming strobe, waits a fixed core latency, and captures the plaintext.
//  It returns the plaintext with the requester ID over a valid/ready output port. Only one decryption
//  is in flight at a time.
// PARAMETERS
//  DDATAW   20  block (ciphertext/plaintext) width; key width is 2*DDATAW
//  LATENCY  36  cycles from the core_incoming pulse to a valid core_plaintext; legal range 2..255
//  CNTW     8   width of the latency counter; must satisfy 2**CNTW > LATENCY
// PORTS
//  clk             in   1         single clock, rising edge
//  reset           in   1         asynchronous, active-high
//  req0_valid      in   1         requester 0 has a ciphertext/key pair
//  req0_ready      out  1         1-cycle accept pulse to requester 0
//  req0_data       in   DDATAW    requester 0 ciphertext
//  req0_key        in   2*DDATAW  requester 0 key
//  req1_valid/ready/data/key      same as requester 0, for requester 1
//  core_incoming   out  1         start strobe to the decrypter core
//  core_data       out  DDATAW    ciphertext to the core; held stable for the whole job
//  core_key        out  2*DDATAW  key to the core; held stable for the whole job
//  core_plaintext  in   DDATAW    plaintext from the core
//  out_valid       out  1         result available
//  out_ready       in   1         downstream accepts the result
//  out_data        out  DDATAW    captured plaintext
//  out_id          out  1         requester that owns out_data
//  busy            out  1         1 in every state except IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0; state=IDLE; last_grant=1 (so requester 0 wins the first tie); cnt=0.
//  - All outputs are registered except busy, which decodes from state.
//  - FSM IDLE -> LOAD -> RUN -> HOLD -> IDLE.
//  - IDLE: if any reqN_valid is set, pick the grant:
//    - only one valid: grant that requester;
//    - both valid: grant the requester != last_grant.
//    - Latch reqN_data/key into core_data/core_key, set out_id=grant and last_grant=grant.
//    - Pulse reqN_ready for exactly this edge, then go to LOAD. With no valid request, stay in IDLE.
//  - LOAD: core_incoming=1 for exactly one cycle; cnt<=0; go to RUN.
//  - RUN: core_incoming=0; cnt increments each cycle.
//    - When cnt==LATENCY-1: out_data<=core_plaintext, out_valid<=1, go to HOLD.
//  - HOLD: hold out_valid, out_data and out_id stable until out_ready=1.
//    - On that edge: out_valid<=0, go to IDLE. The next grant is possible one cycle later (no bypass).
//  - Request side: a valid request is never dropped.
//    - A requester that loses stays pending; it wins the next IDLE arbitration because of last_grant.
//    - reqN_valid may be deasserted before acceptance; only the valid level in IDLE matters.
//  - reqN_ready is never asserted outside IDLE, and never to both requesters in the same cycle.
//  - Throughput: one job per LATENCY+3 cycles when out_ready is tied to 1.
//  - Reset mid-operation (any state): abort immediately.
//    - Outputs return to their reset values; the in-flight result is discarded.
//    - The core is not restarted until a new grant.
//  - out_ready while out_valid=0 is ignored.
//  - Counter width: LATENCY-1 must be representable in CNTW bits.
// CONFIGURATION
//  SIMECK_ARB_FIXED_PRIO_EN
//  - Defined: fixed priority. Requester 0 always wins when both are valid; last_grant is unused.
//    Requester 1 can starve.
//  - Undefined (default): round-robin as described above.
// TESTING
//  1. Reset, then req0 only with data=20'h1A2B3, key=40'h0123456789:
//     req0_ready pulses 1 cycle after valid; core_incoming pulses the next cycle; out_valid rises
//     LATENCY cycles after that pulse with out_id=0 and out_data=core model plaintext.
//  2. req0_valid and req1_valid both held, out_ready=1:
//     grants alternate 0,1,0,1; each job completes LATENCY+3 cycles after the previous grant.
//  3. out_ready=0 for 10 cycles after out_valid:
//     out_data/out_id stay stable; req1_valid raised meanwhile gets no ready until out_ready=1,
//     then is granted.
//  4. Assert reset during RUN with cnt=5: all outputs go 0 asynchronously, with no out_valid.
//     After release, req1 request: granted first, since the reset value of last_grant favours
//     requester 0 only on ties.
//  5. With SIMECK_ARB_FIXED_PRIO_EN defined and both requesters always valid: only requester 0
//     is granted over 4 jobs.
//  6. core_data/core_key are checked constant from the grant edge until the HOLD exit, while
//     req0_data toggles every cycle.

Source files
------------

// File: rtl/simeck_dec_arbiter.sv
// simeck_dec_arbiter: shares one Simeck decrypter core between two requesters.
// The winning request's ciphertext/key are latched and held on the core inputs,
// the core is strobed, and after a fixed latency the plaintext is returned with
// the requester ID over a valid/ready port. One job is in flight at a time.
// Optional build macro SIMECK_ARB_FIXED_PRIO_EN: requester 0 always wins ties
// (requester 1 can starve). Without it, ties are resolved round-robin.
// LATENCY must lie in 2..255 and LATENCY-1 must fit in CNTW bits.
module simeck_dec_arbiter #(
    parameter int DDATAW  = 20,
    parameter int LATENCY = 36,
    parameter int CNTW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DDATAW-1:0]     req0_data,
    input  logic [2*DDATAW-1:0]   req0_key,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DDATAW-1:0]     req1_data,
    input  logic [2*DDATAW-1:0]   req1_key,
    output logic                  core_incoming,
    output logic [DDATAW-1:0]     core_data,
    output logic [2*DDATAW-1:0]   core_key,
    input  logic [DDATAW-1:0]     core_plaintext,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DDATAW-1:0]     out_data,
    output logic                  out_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_req0_ready;
    logic                  r_req1_ready;
    logic                  r_core_incoming;
    logic [DDATAW-1:0]     r_core_data;
    logic [2*DDATAW-1:0]   r_core_key;
    logic                  r_out_valid;
    logic [DDATAW-1:0]     r_out_data;
    logic                  r_out_id;
    logic [CNTW-1:0]       r_cnt;
    logic                  w_any_req;
    logic                  w_grant;
    logic                  w_cnt_done;

    assign w_any_req  = req0_valid | req1_valid;
    assign w_cnt_done = (r_cnt == CNTW'(LATENCY - 1));

`ifdef SIMECK_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 is granted only when requester 0 is idle.
    assign w_grant = ~req0_valid;
`else
    logic r_last_grant;

    // Ties go to the requester that was not granted last; a lone request wins outright.
    assign w_grant = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

    // Remember the most recent grant; reset value makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_RUN;
            S_RUN:   if (w_cnt_done) w_next_state = S_HOLD;
            S_HOLD:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs and datapath: grant/latch, core strobe, latency count, result hold.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_req0_ready    <= 1'b0;
            r_req1_ready    <= 1'b0;
            r_core_incoming <= 1'b0;
            r_core_data     <= '0;
            r_core_key      <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_id        <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_req0_ready    <= 1'b0;
            r_req1_ready    <= 1'b0;
            r_core_incoming <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        if (w_grant) begin
                            r_core_data  <= req1_data;
                            r_core_key   <= req1_key;
                            r_req1_ready <= 1'b1;
                        end else begin
                            r_core_data  <= req0_data;
                            r_core_key   <= req0_key;
                            r_req0_ready <= 1'b1;
                        end
                        r_out_id <= w_grant;
                    end
                end
                S_LOAD: begin
                    r_core_incoming <= 1'b1;
                    r_cnt           <= '0;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_cnt_done) begin
                        r_out_data  <= core_plaintext;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready    = r_req0_ready;
    assign req1_ready    = r_req1_ready;
    assign core_incoming = r_core_incoming;
    assign core_data     = r_core_data;
    assign core_key      = r_core_key;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_id        = r_out_id;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_simeck_dec_arbiter.sv
// Testbench for simeck_dec_arbiter: table of arbitration vectors plus hand-written
// sequences (first job latency, output back-pressure, mid-job reset, input toggling).
// A behavioural core stand-in produces a keyed plaintext exactly LATENCY cycles after
// the strobe; a scoreboard queue holds the expected result of every accepted request.
module tb_simeck_dec_arbiter;

    localparam int DW  = 20;
    localparam int LAT = 36;
    localparam int CW  = 8;
`ifdef SIMECK_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0]   req0_data, req1_data;
    logic [2*DW-1:0] req0_key, req1_key;
    logic            core_incoming;
    logic [DW-1:0]   core_data, core_plaintext;
    logic [2*DW-1:0] core_key;
    logic            out_valid, out_ready, out_id, busy;
    logic [DW-1:0]   out_data;

    always #5 clk = ~clk;

    simeck_dec_arbiter #(.DDATAW(DW), .LATENCY(LAT), .CNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
        .core_incoming(core_incoming), .core_data(core_data), .core_key(core_key),
        .core_plaintext(core_plaintext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .busy(busy)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stand-in for the decrypter: any keyed, data-dependent mapping will do.
    function automatic logic [DW-1:0] pt_of(input logic [DW-1:0] d, input logic [2*DW-1:0] k);
        return d ^ k[DW-1:0] ^ {k[DW+3:DW], k[2*DW-1:DW+4]};
    endfunction

    // Core model: junk after the strobe, correct plaintext valid LAT cycles after it.
    int m_cnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt          <= 0;
            core_plaintext <= '0;
        end else if (core_incoming) begin
            m_cnt          <= 1;
            core_plaintext <= 20'hDEAD0;
        end else if (m_cnt == LAT - 2) begin
            m_cnt          <= 0;
            core_plaintext <= pt_of(core_data, core_key);
        end else if (m_cnt != 0) begin
            m_cnt          <= m_cnt + 1;
            core_plaintext <= core_plaintext ^ 20'h00001;
        end
    end

    // Request values as seen by the DUT at each edge, and a free-running cycle count.
    logic [DW-1:0]   s_d0, s_d1;
    logic [2*DW-1:0] s_k0, s_k1;
    int              cyc = 0;
    always @(posedge clk) begin
        s_d0 <= req0_data;
        s_d1 <= req1_data;
        s_k0 <= req0_key;
        s_k1 <= req1_key;
        cyc  <= cyc + 1;
    end

    // Scoreboard and hold monitor.
    typedef struct packed {
        logic          id;
        logic [DW-1:0] pt;
    } exp_t;
    exp_t            sb[$];
    exp_t            e;
    logic [DW-1:0]   exp_cd = '0;
    logic [2*DW-1:0] exp_ck = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (req0_ready || req1_ready) begin
                check("ready_excl", req0_ready & req1_ready, 0);
                if (req1_ready) begin
                    sb.push_back('{id: 1'b1, pt: pt_of(s_d1, s_k1)});
                    exp_cd = s_d1;
                    exp_ck = s_k1;
                end else begin
                    sb.push_back('{id: 1'b0, pt: pt_of(s_d0, s_k0)});
                    exp_cd = s_d0;
                    exp_ck = s_k0;
                end
            end
            if (busy) begin
                check("core_data_hold", core_data, exp_cd);
                check("core_key_hold", core_key, exp_ck);
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_id", out_id, e.id);
                    check("out_data", out_data, e.pt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 2 * LAT + 10; i++) begin
            tick();
            n++;
            if (req0_ready || req1_ready) break;
        end
        check("ready_seen", req0_ready | req1_ready, 1);
    endtask

    // Waits for out_valid then steps through the handshake edge (out_ready must be 1).
    task automatic wait_out();
        for (int i = 0; i < 2 * LAT + 10; i++) begin
            tick();
            if (out_valid) break;
        end
        check("out_seen", out_valid, 1);
        tick();
    endtask

    typedef struct {
        logic            v0, v1;
        logic [DW-1:0]   d0, d1;
        logic [2*DW-1:0] k0, k1;
        logic            exp_id;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic v1, input logic id);
        vec_t v;
        v.v0 = v0;
        v.v1 = v1;
        v.d0 = DW'($urandom);
        v.d1 = DW'($urandom);
        v.k0 = (2*DW)'({$urandom, $urandom});
        v.k1 = (2*DW)'({$urandom, $urandom});
        v.exp_id = (FIXED && v0 && v1) ? 1'b0 : id;
        return v;
    endfunction

    vec_t            vt[10];
    int              n, last_cyc;
    logic            seen;
    logic [DW-1:0]   t1_pt;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin expectations from reset (last_grant=1); fixed priority overrides ties to 0.
        vt[0] = mk(1, 1, 0); vt[1] = mk(1, 1, 1); vt[2] = mk(1, 1, 0); vt[3] = mk(1, 1, 1);
        vt[4] = mk(0, 1, 1); vt[5] = mk(0, 1, 1); vt[6] = mk(1, 1, 0); vt[7] = mk(1, 0, 0);
        vt[8] = mk(1, 1, 1); vt[9] = mk(1, 1, 0);

        req0_valid = 0; req1_valid = 0; out_ready = 0;
        req0_data = '0; req1_data = '0; req0_key = '0; req1_key = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {req0_ready, req1_ready, core_incoming, out_valid, out_id, busy}, 0);
        check("rst_data", {core_data, core_key, out_data}, 0);
        reset = 0;

        // Table: back-to-back jobs with out_ready tied high.
        out_ready = 1;
        last_cyc  = 0;
        for (int i = 0; i < 10; i++) begin
            req0_valid = vt[i].v0; req0_data = vt[i].d0; req0_key = vt[i].k0;
            req1_valid = vt[i].v1; req1_data = vt[i].d1; req1_key = vt[i].k1;
            wait_ready(n);
            check($sformatf("grant[%0d]", i), req1_ready, vt[i].exp_id);
            if (i > 0) check($sformatf("grant_gap[%0d]", i), cyc - last_cyc, LAT + 3);
            last_cyc = cyc;
        end
        req0_valid = 0; req1_valid = 0;
        wait_out();
        check("idle_after_table", busy, 0);

        // First-job timing, then back-pressure with a pending requester 1.
        out_ready  = 0;
        req0_valid = 1; req0_data = 20'h1A2B3; req0_key = 40'h0123456789;
        t1_pt      = pt_of(20'h1A2B3, 40'h0123456789);
        tick();
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        req0_valid = 0;
        tick();
        check("t1_incoming", core_incoming, 1);
        check("t1_core_data", core_data, 20'h1A2B3);
        check("t1_core_key", core_key, 40'h0123456789);
        n = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            tick();
            n++;
            if (n == 1) check("t1_incoming_pulse", core_incoming, 0);
            if (out_valid) break;
        end
        check("t1_latency", n, LAT);
        check("t1_id", out_id, 0);
        check("t1_data", out_data, t1_pt);
        req1_valid = 1; req1_data = 20'h55AA5; req1_key = 40'hFEDCBA9876;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_valid_held", out_valid, 1);
            check("t3_data_held", out_data, t1_pt);
            check("t3_id_held", out_id, 0);
            check("t3_no_ready1", req1_ready, 0);
        end
        out_ready = 1;
        tick();
        check("t3_valid_drop", out_valid, 0);
        check("t3_no_bypass", req1_ready, 0);
        tick();
        check("t3_grant1", req1_ready, 1);
        req1_valid = 0;
        wait_out();

        // Reset in RUN with cnt=5 discards the job; afterwards a lone req1 is granted.
        req0_valid = 1; req0_data = 20'h0F0F0; req0_key = 40'h1111122222;
        wait_ready(n);
        req0_valid = 0;
        tick();
        check("t4_incoming", core_incoming, 1);
        repeat (5) tick();
        #2 reset = 1;
        #1;
        check("t4_rst_ctrl", {req0_ready, req1_ready, core_incoming, out_valid, out_id, busy}, 0);
        check("t4_rst_data", {core_data, core_key, out_data}, 0);
        sb.delete();
        tick();
        tick();
        reset = 0;
        seen = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            tick();
            seen = seen | out_valid | core_incoming | busy;
        end
        check("t4_quiet_after_reset", seen, 0);
        req1_valid = 1; req1_data = 20'h33333; req1_key = 40'h4444455555;
        wait_ready(n);
        check("t4_grant1", req1_ready, 1);
        check("t4_grant_latency", n, 1);
        req1_valid = 0;
        wait_out();

        // req0_data toggles every cycle; the hold monitor checks core_data/core_key.
        req0_valid = 1; req0_data = 20'hA5A5A; req0_key = 40'h0F1E2D3C4B;
        seen = 0;
        for (int i = 0; i < 2 * LAT + 10; i++) begin
            tick();
            req0_data = ~req0_data;
            if (req0_ready) begin
                seen = 1;
                req0_valid = 0;
            end
            if (out_valid) break;
        end
        check("t6_granted", seen, 1);
        check("t6_out_valid", out_valid, 1);
        tick();
        check("t6_idle", busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
